// File: rtl/tx_symbol_serializer_if.sv
// rtl/tx_symbol_serializer_if.sv - symbol handshake between upstream encoder and serializer
interface tx_symbol_serializer_if;
    logic [9:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/tx_symbol_serializer.sv
// rtl/tx_symbol_serializer.sv - 8b/10b symbol serializer with comma alignment, SKP insertion and RD tracking
module tx_symbol_serializer #(
    parameter int unsigned ALIGN_COUNT  = 8,
    parameter int unsigned SKP_INTERVAL = 1180
) (
    input  logic                   clock,
    input  logic                   Reset,
    tx_symbol_serializer_if.slave  tx,
    output logic                   data_out,
    output logic                   SYMBOL_CLK,
    output logic                   SKP_SENT,
    output logic                   ALIGNED,
    output logic                   RD,
    output logic                   CODE_ERROR
);

    localparam logic [9:0] K28_5_NEG  = 10'b0011111010;
    localparam logic [9:0] K28_5_POS  = 10'b1100000101;
    localparam logic [9:0] K28_0_NEG  = 10'b0011110100;
    localparam logic [9:0] K28_0_POS  = 10'b1100001011;
    localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_COUNT);

    typedef enum logic [2:0] {
        ST_ALIGN,
        ST_DATA,
        ST_SKP_COM,
        ST_SKP1,
        ST_SKP2,
        ST_SKP3
    } state_t;

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    state_t      state;
    state_t      state_next;

    logic [9:0]  sreg;
    logic [3:0]  bit_cnt;
    logic        rd;
    logic [7:0]  align_cnt;
    logic [15:0] skp_cnt;

    logic        load;
    logic        skp_due;
    logic        align_done;
    logic        data_slot;
    logic        tx_ready_int;
    logic        accept;

    logic [9:0]  k28_5;
    logic [9:0]  k28_0;
    logic [9:0]  next_sym;
    logic [3:0]  next_pop;
    logic        rd_next;
    logic        sym_is_data;
    logic        align_inc;
    logic        skp_clr;
    logic        skp_inc;
    logic        skp_pulse;

    assign load         = (bit_cnt == 4'd9);
    assign skp_due      = (SKP_INTERVAL != 0) && (32'(skp_cnt) >= SKP_INTERVAL);
    assign align_done   = (state == ST_ALIGN) && (align_cnt == ALIGN_LAST);
    // The final alignment load behaves as a DATA load, but the handshake stays closed for it.
    assign data_slot    = (state == ST_DATA) || align_done;
    assign tx_ready_int = load && (state == ST_DATA) && !skp_due;
    assign accept       = tx_ready_int && tx.tx_valid;
    assign tx.tx_ready  = tx_ready_int;

    assign k28_5 = rd ? K28_5_POS : K28_5_NEG;
    assign k28_0 = rd ? K28_0_POS : K28_0_NEG;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_ALIGN;
        end else if (load) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ALIGN:   if (align_done) state_next = skp_due ? ST_SKP1 : ST_DATA;
            ST_DATA:    if (skp_due) state_next = ST_SKP1;
            ST_SKP_COM: state_next = ST_SKP1;
            ST_SKP1:    state_next = ST_SKP2;
            ST_SKP2:    state_next = ST_SKP3;
            ST_SKP3:    state_next = ST_DATA;
            default:    state_next = ST_ALIGN;
        endcase
    end

    always_comb begin
        next_sym    = k28_5;
        sym_is_data = 1'b0;
        align_inc   = 1'b0;
        skp_clr     = 1'b0;
        skp_inc     = 1'b0;
        skp_pulse   = 1'b0;
        if (data_slot) begin
            if (skp_due) begin
                next_sym  = k28_0;
                skp_clr   = 1'b1;
                skp_pulse = load;
            end else begin
                next_sym    = accept ? tx.tx_data : k28_5;
                sym_is_data = accept;
                skp_inc     = 1'b1;
            end
        end else begin
            case (state)
                ST_ALIGN: begin
                    next_sym  = k28_5;
                    align_inc = 1'b1;
                end
                ST_SKP_COM: begin
                    next_sym  = k28_0;
                    skp_pulse = load;
                end
                ST_SKP1, ST_SKP2, ST_SKP3: next_sym = k28_0;
                default: next_sym = k28_5;
            endcase
        end
    end

    assign next_pop = popcount10(next_sym);

    always_comb begin
        rd_next = rd;
        case (next_pop)
            4'd6:    rd_next = 1'b1;
            4'd4:    rd_next = 1'b0;
            default: rd_next = rd;
        endcase
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            sreg      <= K28_5_NEG;
            bit_cnt   <= 4'd0;
            rd        <= 1'b1;
            align_cnt <= 8'd1;
            skp_cnt   <= 16'd0;
        end else if (load) begin
            sreg    <= next_sym;
            bit_cnt <= 4'd0;
            rd      <= rd_next;
            if (align_inc) begin
                align_cnt <= align_cnt + 8'd1;
            end
            if (skp_clr) begin
                skp_cnt <= 16'd0;
            end else if (skp_inc && skp_cnt != 16'hFFFF) begin
                skp_cnt <= skp_cnt + 16'd1;
            end
        end else begin
            sreg    <= {sreg[8:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    assign data_out   = sreg[9];
    assign SYMBOL_CLK = load;
    assign SKP_SENT   = skp_pulse;
    assign ALIGNED    = (state != ST_ALIGN) || (align_done && load);
    assign RD         = rd;
    assign CODE_ERROR = sym_is_data && !(next_pop inside {4'd4, 4'd5, 4'd6});

endmodule

// File: tb/tb_tx_symbol_serializer.sv
// tb/tb_tx_symbol_serializer.sv - directed bench for tx_symbol_serializer
module tb_tx_symbol_serializer;

    localparam logic [9:0] K5N = 10'b0011111010;
    localparam logic [9:0] K5P = 10'b1100000101;
    localparam logic [9:0] K0N = 10'b0011110100;
    localparam logic [9:0] K0P = 10'b1100001011;
    localparam logic [9:0] D1  = 10'b1010101010;
    localparam logic [9:0] D2  = 10'b0110001011;
    localparam logic [9:0] D3  = 10'b0100011100;
    localparam logic [9:0] D4  = 10'b1111111000;
    localparam logic [9:0] D5  = 10'b1100110010;

    logic clock = 1'b0;
    logic Reset;
    logic data_out;
    logic SYMBOL_CLK;
    logic SKP_SENT;
    logic ALIGNED;
    logic RD;
    logic CODE_ERROR;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    tx_symbol_serializer_if bus ();

    tx_symbol_serializer #(
        .ALIGN_COUNT (8),
        .SKP_INTERVAL(4)
    ) dut (
        .clock     (clock),
        .Reset     (Reset),
        .tx        (bus),
        .data_out  (data_out),
        .SYMBOL_CLK(SYMBOL_CLK),
        .SKP_SENT  (SKP_SENT),
        .ALIGNED   (ALIGNED),
        .RD        (RD),
        .CODE_ERROR(CODE_ERROR)
    );

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Call at the negedge of a load cycle; checks the load-cycle strobes.
    task automatic chk_flags(input string tag, input logic r, input logic s,
                             input logic e, input logic a);
        chk({tag, " flags"},
            {5'b0, SYMBOL_CLK, bus.tx_ready, SKP_SENT, CODE_ERROR, ALIGNED},
            {5'b0, 1'b1, r, s, e, a});
    endtask

    // Collects the next 10 line bits; inputs for the following load are set just after its posedge.
    task automatic rx_chk(input string tag, input logic [9:0] exp_sym, input logic exp_rd,
                          input logic nv, input logic [9:0] nd);
        logic [9:0] s;
        s = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                @(posedge clock);
                #1;
                bus.tx_valid = nv;
                bus.tx_data  = nd;
            end
            @(negedge clock);
            s = {s[8:0], data_out};
            if (i < 9) begin
                chk({tag, " idle"}, {6'b0, SYMBOL_CLK, bus.tx_ready, SKP_SENT, CODE_ERROR}, 10'd0);
            end
        end
        chk({tag, " symbol"}, s, exp_sym);
        chk({tag, " rd"}, {9'b0, RD}, {9'b0, exp_rd});
    endtask

    task automatic step(input string tag, input logic r, input logic s, input logic e,
                        input logic a, input logic [9:0] exp_sym, input logic exp_rd,
                        input logic nv, input logic [9:0] nd);
        chk_flags(tag, r, s, e, a);
        rx_chk(tag, exp_sym, exp_rd, nv, nd);
    endtask

    initial begin
        logic [4:0] part;
        Reset        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clock);
        chk("reset values",
            {3'b0, data_out, bus.tx_ready, SYMBOL_CLK, SKP_SENT, CODE_ERROR, ALIGNED, RD},
            10'b0000000001);

        @(posedge clock);
        #1 Reset = 1'b1;
        rx_chk("reset comma", K5N, 1'b1, 1'b0, 10'd0);

        // Alignment: loads 1..7 alternate commas, load 8 closes alignment with fill.
        step("align1", 0, 0, 0, 0, K5P, 0, 0, 10'd0);
        step("align2", 0, 0, 0, 0, K5N, 1, 0, 10'd0);
        step("align3", 0, 0, 0, 0, K5P, 0, 0, 10'd0);
        step("align4", 0, 0, 0, 0, K5N, 1, 0, 10'd0);
        step("align5", 0, 0, 0, 0, K5P, 0, 0, 10'd0);
        step("align6", 0, 0, 0, 0, K5N, 1, 0, 10'd0);
        step("align7", 0, 0, 0, 0, K5P, 0, 0, 10'd0);
        step("align8", 0, 0, 0, 1, K5N, 1, 1, D1);

        step("data1", 1, 0, 0, 1, D1, 1, 1, D2);
        step("data2", 1, 0, 0, 1, D2, 1, 1, D3);
        step("data3", 1, 0, 0, 1, D3, 0, 1, D4);

        // SKP ordered set at RD-, data held off throughout.
        step("skp com", 0, 1, 0, 1, K0N, 0, 1, D4);
        step("skp1", 0, 0, 0, 1, K0N, 0, 1, D4);
        step("skp2", 0, 0, 0, 1, K0N, 0, 1, D4);
        step("skp3", 0, 0, 0, 1, K0N, 0, 1, D4);

        step("bad popcount", 1, 0, 1, 1, D4, 0, 0, 10'd0);

        step("fill1", 1, 0, 0, 1, K5N, 1, 0, 10'd0);
        step("fill2", 1, 0, 0, 1, K5P, 0, 0, 10'd0);
        step("fill3", 1, 0, 0, 1, K5N, 1, 0, 10'd0);

        // SKP ordered set at RD+.
        step("skp+ com", 0, 1, 0, 1, K0P, 1, 0, 10'd0);
        step("skp+ 1", 0, 0, 0, 1, K0P, 1, 0, 10'd0);
        step("skp+ 2", 0, 0, 0, 1, K0P, 1, 0, 10'd0);
        step("skp+ 3", 0, 0, 0, 1, K0P, 1, 1, D5);

        chk_flags("data5", 1, 0, 0, 1);
        part = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            part = {part[3:0], data_out};
        end
        chk("data5 head bits", {5'b0, part}, {5'b0, D5[9:5]});

        #1 Reset = 1'b0;
        #1;
        chk("mid-symbol reset",
            {3'b0, data_out, bus.tx_ready, SYMBOL_CLK, SKP_SENT, CODE_ERROR, ALIGNED, RD},
            10'b0000000001);

        repeat (2) @(posedge clock);
        #1 Reset = 1'b1;
        rx_chk("realign comma", K5N, 1'b1, 1'b1, D5);
        step("realign1", 0, 0, 0, 0, K5P, 0, 1, D5);
        step("realign2", 0, 0, 0, 0, K5N, 1, 1, D5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
